wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB stage register: takes the latched pc_plus4, inst, alu_out and ld_data, and decodes inst (RV32I).
- Selects and formats the write-back value, including load byte/half extraction and sign extension.
- Commits the value into the 32x32 architectural register file.
- Serves two combinational read ports to ID with write-through bypass, exports the WB forwarding triple to the hazard/forwarding unit, and keeps a retired-instruction counter.

Parameters:
- addrWidth, 16, width of pc_plus4; zero-extended to 32 bits on JAL/JALR write-back.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Stall  input  1  when high, no register-file write and no counter increment this cycle.
- pc_plus4  input  addrWidth  return address from WB stage register.
- inst  input  32  instruction in WB; 32'd0 is a bubble.
- alu_out  input  32  ALU result or load/store address.
- ld_data  input  32  raw aligned memory word for loads.
- rs1_addr  input  5  ID read port 1 address.
- rs2_addr  input  5  ID read port 2 address.
- rs1_data  output  32  read port 1 data.
- rs2_data  output  32  read port 2 data.
- wb_en  output  1  a write commits this cycle (forwarding).
- wb_rd  output  5  destination register (forwarding).
- wb_data  output  32  formatted write-back value (forwarding).
- retire_cnt  output  32  count of retired non-bubble instructions.

Behaviour:
- Decode: opcode=inst[6:0], rd=inst[11:7], funct3=inst[14:12].
- Write-back source by opcode:
  - LOAD 0000011 -> formatted load.
  - JAL 1101111 or JALR 1100111 -> {zero-pad, pc_plus4}.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111 -> alu_out.
  - STORE, BRANCH, SYSTEM, FENCE, any other opcode -> no write.
- Load formatting (lane select: byte by alu_out[1:0], half by alu_out[1]):
  - LB 000 -> sign-extend selected byte.
  - LBU 100 -> zero-extend selected byte.
  - LH 001 -> sign-extend selected half.
  - LHU 101 -> zero-extend selected half.
  - LW 010 -> ld_data unchanged.
  - Any other funct3 -> no write.
  - Misaligned half (alu_out[0]=1) or word: the low bits are ignored, with no trap.
- wb_en = writing opcode AND valid funct3 (loads only) AND rd!=0 AND !Stall AND !rst.
  - wb_en, wb_rd and wb_data are combinational from the inputs.
  - wb_rd=rd and wb_data=formatted value always, even when wb_en=0.
- Register file:
  - x1..x31 written on posedge clk when wb_en=1.
  - x0 is never written and always reads 0.
- Read ports (combinational):
  - rsN_addr==0 -> 0.
  - Else if wb_en and rsN_addr==wb_rd -> wb_data (same-cycle bypass).
  - Else the stored value.
  - Both ports may address the same register.
- retire_cnt increments by 1 on posedge clk when !Stall and inst!=32'd0, independent of wb_en (stores and branches count). It wraps from 0xFFFFFFFF to 0.
- Reset:
  - rst high clears all 31 registers and retire_cnt to 0 immediately, regardless of clk.
  - While rst is high, no writes or increments occur; rs1_data and rs2_data read 0 and wb_en=0.
  - Deassertion mid-stream: the first posedge with rst low acts on the inputs present at that edge.
- Stall held for N cycles: the register file and counter hold. A pending write commits once, on the first unstalled edge.
- Latency:
  - A write is visible through the bypass in the same cycle and from storage on the next cycle.
  - Counter is updated one edge after the instruction is presented.

Test Plan:
- Reset then ADDI x5 result: rst pulse; inst=0x00A00293, alu_out=0x0000000A, one edge.
  - Expect rs1_addr=5 -> 0x0000000A; retire_cnt=1.
- Load formatting: ld_data=0x80FF7F01, inst with rd=6.
  - LB, alu_out=...03 -> x6=0xFFFFFF80.
  - LBU, alu_out=...01 -> 0x0000007F.
  - LH, alu_out=...02 -> 0xFFFF80FF.
  - LHU, alu_out=...00 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- JAL rd=1 with pc_plus4=16'h1234:
  - Same cycle: rs2_addr=1 bypasses 0x00001234.
  - Next cycle: the stored value reads 0x00001234.
- x0 and non-writers:
  - ADD with rd=0, alu_out=0xDEADBEEF -> wb_en=0, x0 reads 0.
  - SW -> no write, retire_cnt still increments.
  - Bubble inst=0 -> counter unchanged.
- Stall: LUI x7 (alu_out=0x12345000) with Stall=1 for 3 edges.
  - Expect x7 unchanged and retire_cnt unchanged.
  - Release Stall -> x7=0x12345000 and counter +1.
- Async reset mid-run: assert rst between clock edges with x5 nonzero.
  - Expect rs1_data=0 and retire_cnt=0 before the next edge.
  - Forcing retire_cnt to 0xFFFFFFFF and retiring one instruction -> 0.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : RV32I write-back stage: load formatting, 32x32 register file
//            with write-through read ports, forwarding triple and
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int addrWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Stall,
    input  logic [addrWidth-1:0] pc_plus4,
    input  logic [31:0]          inst,
    input  logic [31:0]          alu_out,
    input  logic [31:0]          ld_data,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_data,
    output logic [31:0]          rs2_data,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic [31:0]          retire_cnt
);

    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_JAL   = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR  = 7'b1100111;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ret_addr;
    logic [31:0] w_load_val;
    logic        w_load_ok;
    logic [31:0] w_fmt;
    logic        w_writes;

    logic [31:0] r_regs [1:31];
    logic [31:0] r_retire_cnt;

    assign w_opcode   = inst[6:0];
    assign w_rd       = inst[11:7];
    assign w_funct3   = inst[14:12];
    assign w_ret_addr = 32'(pc_plus4);

    // Misaligned halves/words simply drop the low address bits.
    assign w_byte = ld_data[{alu_out[1:0], 3'b000} +: 8];
    assign w_half = alu_out[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        w_load_ok  = 1'b1;
        w_load_val = ld_data;
        case (w_funct3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_val = {16'd0, w_half};
            3'b010:  w_load_val = ld_data;
            default: w_load_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_writes = 1'b0;
        w_fmt    = alu_out;
        case (w_opcode)
            c_OPC_LOAD: begin
                w_writes = w_load_ok;
                w_fmt    = w_load_val;
            end
            c_OPC_JAL, c_OPC_JALR: begin
                w_writes = 1'b1;
                w_fmt    = w_ret_addr;
            end
            c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI, c_OPC_AUIPC: begin
                w_writes = 1'b1;
                w_fmt    = alu_out;
            end
            default: w_writes = 1'b0;
        endcase
    end

    assign wb_en   = w_writes && (w_rd != 5'd0) && !Stall && !rst;
    assign wb_rd   = w_rd;
    assign wb_data = w_fmt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en) begin
            r_regs[w_rd] <= w_fmt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (!Stall && (inst != 32'd0)) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;

    // A commit in flight is visible to ID in the same cycle.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return 32'd0;
        end else if (wb_en && (addr == w_rd)) begin
            return w_fmt;
        end else begin
            return r_regs[addr];
        end
    endfunction

    assign rs1_data = read_port(rs1_addr);
    assign rs2_data = read_port(rs2_addr);

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Randomized self-checking bench for wb_regfile with a behavioural
//            register-file model and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Stall = 1'b0;
    logic [15:0] pc_plus4 = '0;
    logic [31:0] inst = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] ld_data = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    wb_regfile #(.addrWidth(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (Stall),
        .pc_plus4   (pc_plus4),
        .inst       (inst),
        .alu_out    (alu_out),
        .ld_data    (ld_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-back value derived arithmetically from the instruction rules.
    function automatic void model_wb(input logic [31:0] i, input logic [31:0] a,
                                     input logic [31:0] ld, input logic [15:0] pc,
                                     output bit wr, output logic [31:0] val);
        int unsigned b, h;
        b   = (ld >> (8 * a[1:0])) & 32'hFF;
        h   = (ld >> (16 * (a[1:0] / 2))) & 32'hFFFF;
        wr  = 1'b0;
        val = '0;
        case (i[6:0])
            7'h03: begin
                wr = 1'b1;
                case (i[14:12])
                    3'd0:    val = (b >= 128) ? b + 32'hFFFFFF00 : b;
                    3'd4:    val = b;
                    3'd1:    val = (h >= 32768) ? h + 32'hFFFF0000 : h;
                    3'd5:    val = h;
                    3'd2:    val = ld;
                    default: wr  = 1'b0;
                endcase
            end
            7'h6F, 7'h67: begin wr = 1'b1; val = 32'(pc); end
            7'h33, 7'h13, 7'h37, 7'h17: begin wr = 1'b1; val = a; end
            default: wr = 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        bit          wr;
        bit          en;
        logic [31:0] val;
        logic [4:0]  rd;
        logic [31:0] e1, e2;
        if (rst) begin
            for (int k = 0; k < 32; k++) m_regs[k] = '0;
            m_cnt = '0;
            check("rst_wb_en", 32'(wb_en), 32'd0);
            check("rst_rs1", rs1_data, 32'd0);
            check("rst_rs2", rs2_data, 32'd0);
            check("rst_cnt", retire_cnt, 32'd0);
        end else begin
            model_wb(inst, alu_out, ld_data, pc_plus4, wr, val);
            rd = inst[11:7];
            en = wr && (rd != 5'd0) && !Stall;
            e1 = (rs1_addr == 0) ? 32'd0 : (en && rs1_addr == rd) ? val : m_regs[rs1_addr];
            e2 = (rs2_addr == 0) ? 32'd0 : (en && rs2_addr == rd) ? val : m_regs[rs2_addr];
            check("wb_en", 32'(wb_en), 32'(en));
            if (wr) begin
                check("wb_rd", 32'(wb_rd), 32'(rd));
                check("wb_data", wb_data, val);
            end
            check("rs1_data", rs1_data, e1);
            check("rs2_data", rs2_data, e2);
            check("retire_cnt", retire_cnt, m_cnt);
            if (en) m_regs[rd] = val;
            if (!Stall && inst != 32'd0) m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                           input string name);
        inst    = (32'(f3) << 12) | (32'd6 << 7) | 32'h03;
        alu_out = a;
        tick();
        inst     = '0;
        rs1_addr = 5'd6;
        #1;
        check(name, rs1_data, exp);
    endtask

    initial begin
        int r;
        // Reset holds everything at zero even with a writer presented.
        inst    = 32'h00A00293;
        alu_out = 32'h0000000A;
        rs1_addr = 5'd5;
        #2;
        check("lit_rst_wb_en", 32'(wb_en), 32'd0);
        check("lit_rst_cnt", retire_cnt, 32'd0);
        inst = '0;
        tick();
        tick();
        rst = 1'b0;

        inst    = 32'h00A00293;
        alu_out = 32'h0000000A;
        tick();
        inst = '0;
        #1;
        check("lit_addi_x5", rs1_data, 32'h0000000A);
        check("lit_addi_cnt", retire_cnt, 32'd1);

        ld_data = 32'h80FF7F01;
        do_load(3'd0, 32'h00001003, 32'hFFFFFF80, "lit_lb");
        do_load(3'd4, 32'h00001001, 32'h0000007F, "lit_lbu");
        do_load(3'd1, 32'h00001002, 32'hFFFF80FF, "lit_lh");
        do_load(3'd5, 32'h00001000, 32'h00007F01, "lit_lhu");
        do_load(3'd2, 32'h00001000, 32'h80FF7F01, "lit_lw");

        inst     = 32'h000000EF;
        pc_plus4 = 16'h1234;
        rs2_addr = 5'd1;
        #1;
        check("lit_jal_bypass", rs2_data, 32'h00001234);
        tick();
        inst = '0;
        #1;
        check("lit_jal_stored", rs2_data, 32'h00001234);
        check("lit_jal_cnt", retire_cnt, 32'd7);

        inst     = 32'h00000033;
        alu_out  = 32'hDEADBEEF;
        rs1_addr = 5'd0;
        #1;
        check("lit_x0_wb_en", 32'(wb_en), 32'd0);
        check("lit_x0_read", rs1_data, 32'd0);
        tick();

        inst = 32'h0062A423;
        #1;
        check("lit_sw_wb_en", 32'(wb_en), 32'd0);
        tick();
        inst     = '0;
        rs1_addr = 5'd8;
        #1;
        check("lit_sw_x8", rs1_data, 32'd0);
        check("lit_sw_cnt", retire_cnt, 32'd9);
        tick();
        check("lit_bubble_cnt", retire_cnt, 32'd9);

        inst     = 32'h000003B7;
        alu_out  = 32'h12345000;
        Stall    = 1'b1;
        rs1_addr = 5'd7;
        tick();
        tick();
        tick();
        check("lit_stall_x7", rs1_data, 32'd0);
        check("lit_stall_cnt", retire_cnt, 32'd9);
        Stall = 1'b0;
        tick();
        inst = '0;
        #1;
        check("lit_unstall_x7", rs1_data, 32'h12345000);
        check("lit_unstall_cnt", retire_cnt, 32'd10);

        // Randomized traffic over all opcode classes, stalls and bubbles.
        repeat (2000) begin
            tick();
            r = $urandom_range(0, 11);
            inst = $urandom;
            case (r)
                0: inst[6:0] = 7'h03;
                1: inst[6:0] = 7'h6F;
                2: inst[6:0] = 7'h67;
                3: inst[6:0] = 7'h33;
                4: inst[6:0] = 7'h13;
                5: inst[6:0] = 7'h37;
                6: inst[6:0] = 7'h17;
                7: inst[6:0] = 7'h23;
                8: inst[6:0] = 7'h63;
                9: inst[6:0] = 7'h03;
                10: inst = '0;
                default: inst[6:0] = 7'($urandom);
            endcase
            alu_out  = $urandom;
            ld_data  = $urandom;
            pc_plus4 = 16'($urandom);
            Stall    = ($urandom_range(0, 4) == 0);
            rs1_addr = ($urandom_range(0, 3) == 0) ? inst[11:7] : 5'($urandom);
            rs2_addr = 5'($urandom);
        end
        tick();
        Stall = 1'b0;

        inst     = 32'h00A00293;
        alu_out  = 32'h0000000A;
        rs1_addr = 5'd5;
        tick();
        inst = '0;
        #1;
        check("lit_pre_rst_x5", rs1_data, 32'h0000000A);
        rst = 1'b1;
        #1;
        check("lit_async_rst_x5", rs1_data, 32'd0);
        check("lit_async_rst_cnt", retire_cnt, 32'd0);
        tick();
        rst = 1'b0;

        force dut.r_retire_cnt = 32'hFFFFFFFF;
        m_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_retire_cnt;
        inst    = 32'h00A00293;
        alu_out = 32'h00000001;
        tick();
        inst = '0;
        #1;
        check("lit_cnt_wrap", retire_cnt, 32'd0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
